usb_frame_parser: RTL and testbench

Downstream byte-stream parser for the FT245R read engine. Consumes single-cycle byte strobes from the USB read path, locks onto the 12 × 0x55 frame header, and decodes the payload as 16-bit address/data pairs, emitting one register-write strobe per pair. Closes the frame on 8 × 0xAA trailer bytes, then reports frame completion or a framing/timeout error to the register block and the reply path.

---
 rtl/usb_frame_parser.sv | 162 ++++++++++++++++
 tb/tb_usb_frame_parser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_frame_parser.sv
// usb_frame_parser
//   Byte-stream parser behind the FT245R read engine. Locks onto a run of
//   HEADER_KEY_SYMBOL bytes, decodes the payload as big-endian address/data
//   word pairs (one register write per pair) and closes the frame on a run of
//   TRAILER_KEY_SYMBOL bytes. Bad trailers and inter-byte silence abort the
//   frame with an error pulse and code.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   reg_wr              one-cycle write strobe; reg_addr/reg_data held after
//   frame_done          one-cycle pulse, good trailer received
//   frame_error         one-cycle pulse, frame aborted
//   error_code          01 trailer mismatch, 10 timeout, 00 after frame_done
//   pair_count          writes in current/last frame, saturating
//   in_frame            high whenever the parser is not hunting for a header
module usb_frame_parser #(
  parameter int unsigned HEADER_KEY_SYMBOL         = 85,
  parameter int unsigned HEADER_KEY_SYMBOL_NUMBER  = 12,
  parameter int unsigned TRAILER_KEY_SYMBOL        = 170,
  parameter int unsigned TRAILER_KEY_SYMBOL_NUMBER = 8,
  parameter int unsigned WORD_WIDTH                = 16,
  parameter int unsigned TIMEOUT_CYCLES            = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  reg_wr,
  output logic [WORD_WIDTH-1:0] reg_addr,
  output logic [WORD_WIDTH-1:0] reg_data,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [1:0]            error_code,
  output logic [15:0]           pair_count,
  output logic                  in_frame
);

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] ADDR_H  = 3'd1;
  localparam logic [2:0] ADDR_L  = 3'd2;
  localparam logic [2:0] DATA_H  = 3'd3;
  localparam logic [2:0] DATA_L  = 3'd4;
  localparam logic [2:0] TRAILER = 3'd5;

  localparam int HW = $clog2(HEADER_KEY_SYMBOL_NUMBER + 1);
  localparam int TW = $clog2(TRAILER_KEY_SYMBOL_NUMBER + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]    HDR_SYM   = 8'(HEADER_KEY_SYMBOL);
  localparam logic [7:0]    TRL_SYM   = 8'(TRAILER_KEY_SYMBOL);
  localparam logic [HW-1:0] HDR_LAST  = HW'(HEADER_KEY_SYMBOL_NUMBER - 1);
  localparam logic [TW-1:0] TRL_LAST  = TW'(TRAILER_KEY_SYMBOL_NUMBER - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [HW-1:0] hdr_cnt;
  logic [TW-1:0] trl_cnt;
  logic [IW-1:0] idle_cnt;
  logic [7:0]    addr_h, addr_l, data_h;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      hdr_cnt     <= '0;
      trl_cnt     <= '0;
      idle_cnt    <= '0;
      addr_h      <= '0;
      addr_l      <= '0;
      data_h      <= '0;
      reg_wr      <= 1'b0;
      reg_addr    <= '0;
      reg_data    <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      error_code  <= '0;
      pair_count  <= '0;
      in_frame    <= 1'b0;
    end else begin
      reg_wr      <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;

      if (state == HUNT) begin
        idle_cnt <= '0;
        if (rx_valid) begin
          if (rx_data == HDR_SYM) begin
            if (hdr_cnt == HDR_LAST) begin
              hdr_cnt    <= '0;
              pair_count <= '0;
              state      <= ADDR_H;
              in_frame   <= 1'b1;
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
            end
          end else begin
            hdr_cnt <= '0;
          end
        end
      end else if (rx_valid) begin
        // A byte always beats a timeout expiring in the same cycle.
        idle_cnt <= '0;
        case (state)
          // trl_cnt is always 0 in ADDR_H, so a trailer symbol there is
          // handled exactly like the first trailer byte.
          ADDR_H, TRAILER: begin
            if (rx_data == TRL_SYM) begin
              if (trl_cnt == TRL_LAST) begin
                trl_cnt    <= '0;
                frame_done <= 1'b1;
                error_code <= 2'b00;
                state      <= HUNT;
                in_frame   <= 1'b0;
              end else begin
                trl_cnt <= trl_cnt + 1'b1;
                state   <= TRAILER;
              end
            end else if (state == TRAILER) begin
              trl_cnt     <= '0;
              frame_error <= 1'b1;
              error_code  <= 2'b01;
              state       <= HUNT;
              in_frame    <= 1'b0;
            end else begin
              addr_h <= rx_data;
              state  <= ADDR_L;
            end
          end
          ADDR_L: begin
            addr_l <= rx_data;
            state  <= DATA_H;
          end
          DATA_H: begin
            data_h <= rx_data;
            state  <= DATA_L;
          end
          DATA_L: begin
            reg_addr <= WORD_WIDTH'({addr_h, addr_l});
            reg_data <= WORD_WIDTH'({data_h, rx_data});
            reg_wr   <= 1'b1;
            if (pair_count != '1) pair_count <= pair_count + 16'd1;
            state    <= ADDR_H;
          end
          default: begin
            state    <= HUNT;
            in_frame <= 1'b0;
          end
        endcase
      end else if (idle_cnt == IDLE_LAST) begin
        // This idle cycle brings the count to TIMEOUT_CYCLES.
        idle_cnt    <= '0;
        trl_cnt     <= '0;
        frame_error <= 1'b1;
        error_code  <= 2'b10;
        state       <= HUNT;
        in_frame    <= 1'b0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_frame_parser.sv
// tb_usb_frame_parser
//   Scoreboarded bench for usb_frame_parser. Every expected strobe (write,
//   done, error) is queued with the edge on which it must appear; the monitor
//   pops one entry per observed strobe and compares kind, timing and fields.
module tb_usb_frame_parser;

  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        reg_wr;
  logic [15:0] reg_addr;
  logic [15:0] reg_data;
  logic        frame_done;
  logic        frame_error;
  logic [1:0]  error_code;
  logic [15:0] pair_count;
  logic        in_frame;

  usb_frame_parser #(
    .HEADER_KEY_SYMBOL         (85),
    .HEADER_KEY_SYMBOL_NUMBER  (12),
    .TRAILER_KEY_SYMBOL        (170),
    .TRAILER_KEY_SYMBOL_NUMBER (8),
    .WORD_WIDTH                (16),
    .TIMEOUT_CYCLES            (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .error_code  (error_code),
    .pair_count  (pair_count),
    .in_frame    (in_frame)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  int unsigned last_cap = 0;

  localparam int EV_WR   = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int          kind;
    int unsigned at;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] pc;
    logic [1:0]  ec;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_ev(input int kind, input int unsigned at, input logic [15:0] addr,
                         input logic [15:0] data, input logic [15:0] pc, input logic [1:0] ec);
    ev_t e;
    e.kind = kind; e.at = at; e.addr = addr; e.data = data; e.pc = pc; e.ec = ec;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; byte is captured on the next edge, then two idle cycles.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    last_cap = cyc;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_n(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_byte(b);
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] d, input logic [15:0] pc);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(d[15:8]);
    push_ev(EV_WR, cyc + 1, a, d, pc, 2'b00);
    send_byte(d[7:0]);
  endtask

  task automatic send_trailer(input logic [15:0] pc);
    send_n(8'hAA, 7);
    push_ev(EV_DONE, cyc + 1, '0, '0, pc, 2'b00);
    send_byte(8'hAA);
  endtask

  // Scoreboard monitor: samples on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (reg_wr || frame_done || frame_error)) begin
      check("strobe_onehot", 32'(reg_wr) + 32'(frame_done) + 32'(frame_error), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {29'b0, reg_wr, frame_done, frame_error}, 0);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", reg_wr ? EV_WR : (frame_done ? EV_DONE : EV_ERR), e.kind);
        check("ev_cycle", cyc, e.at);
        if (e.kind == EV_WR) begin
          check("wr_addr", reg_addr, e.addr);
          check("wr_data", reg_data, e.data);
          check("wr_pair_count", pair_count, e.pc);
          check("wr_in_frame", in_frame, 1);
        end else begin
          check("end_error_code", error_code, e.ec);
          check("end_in_frame", in_frame, 0);
          if (e.kind == EV_DONE) check("done_pair_count", pair_count, e.pc);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_reg_wr"}, reg_wr, 0);
    check({tag, "_reg_addr"}, reg_addr, 0);
    check({tag, "_reg_data"}, reg_data, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_error"}, frame_error, 0);
    check({tag, "_error_code"}, error_code, 0);
    check({tag, "_pair_count"}, pair_count, 0);
    check({tag, "_in_frame"}, in_frame, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic frame: one pair.
    send_n(8'h55, 12);
    check("t1_locked", in_frame, 1);
    send_pair(16'h1234, 16'hABCD, 16'd1);
    send_trailer(16'd1);
    check("t1_pair_count", pair_count, 1);
    check("t1_error_code", error_code, 0);
    check("t1_hunt", in_frame, 0);

    // Broken header run, then real header and two pairs.
    send_n(8'h55, 11);
    send_byte(8'h00);
    check("t2_no_lock", in_frame, 0);
    send_n(8'h55, 12);
    check("t2_locked", in_frame, 1);
    check("t2_pc_cleared", pair_count, 0);
    send_pair(16'h0001, 16'h0002, 16'd1);
    send_pair(16'h0003, 16'h0004, 16'd2);
    send_trailer(16'd2);
    check("t2_pair_count", pair_count, 2);

    // Trailer mismatch; the offending 0x55 must not count toward a header.
    send_n(8'h55, 12);
    send_n(8'hAA, 4);
    check("t3_in_trailer", in_frame, 1);
    push_ev(EV_ERR, cyc + 1, '0, '0, '0, 2'b01);
    send_byte(8'h55);
    check("t3_hunt", in_frame, 0);
    check("t3_error_code", error_code, 1);
    send_n(8'h55, 12);
    send_pair(16'h1234, 16'hABCD, 16'd1);
    send_trailer(16'd1);
    check("t3_code_cleared", error_code, 0);

    // Timeout after a partial pair.
    send_n(8'h55, 12);
    send_byte(8'h12);
    send_byte(8'h34);
    push_ev(EV_ERR, last_cap + TMO, '0, '0, '0, 2'b10);
    while (cyc < last_cap + TMO + 2) begin @(posedge clk); #1; end
    check("t4_hunt", in_frame, 0);
    check("t4_error_code", error_code, 2);
    check("t4_pair_count", pair_count, 0);

    // Byte arriving on the expiry cycle keeps the frame alive.
    send_n(8'h55, 12);
    send_byte(8'h12);
    send_byte(8'h34);
    while (cyc < last_cap + TMO - 1) begin @(posedge clk); #1; end
    send_byte(8'hAB);
    check("t4b_alive", in_frame, 1);
    push_ev(EV_WR, cyc + 1, 16'h1234, 16'hABCD, 16'd1, 2'b00);
    send_byte(8'hCD);
    send_trailer(16'd1);

    // Empty frame.
    send_n(8'h55, 12);
    send_trailer(16'd0);
    check("t5_pair_count", pair_count, 0);

    // Thirteenth 0x55 is the address MSB.
    send_n(8'h55, 13);
    send_byte(8'h66);
    send_byte(8'h77);
    push_ev(EV_WR, cyc + 1, 16'h5566, 16'h7788, 16'd1, 2'b00);
    send_byte(8'h88);
    send_trailer(16'd1);

    // Reset mid-pair: no write, then a clean frame.
    send_n(8'h55, 12);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_n(8'h55, 12);
    send_pair(16'h0A0B, 16'h0C0D, 16'd1);
    send_trailer(16'd1);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
